bcd_updown_counter_nd: RTL and testbench

- Parametrised multi-digit successor to the single-digit up/down BCD counter.
- Counts in packed BCD over NUM_DIGITS decades, up or down, with synchronous parallel load, count enable and a terminal-count pulse.
- Loaded data is validated per digit.
- Used as a display or event counter in lab datapaths; the tc output cascades into further instances.

---
 rtl/bcd_updown_counter_nd.sv | 174 +++++++++++++++++
 tb/tb_bcd_updown_counter_nd.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter_nd.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter_nd
//
// Multi-digit packed-BCD up/down counter with synchronous parallel load,
// count enable, a registered terminal-count pulse and a registered
// load-validation flag. Digit 0 lives in bits [3:0].
//
// Optional build macro: BCD_COUNTER_SAT_EN
//   undefined : the count wraps (all-9s -> all-0s going up,
//               all-0s -> all-9s going down), and tc marks the wrap.
//   defined   : the count saturates at the ends of the range, and tc
//               pulses on every edge where a count request is blocked.
//
// The tc output is meant to drive the en input of a further instance.
// ---------------------------------------------------------------------------
module bcd_updown_counter_nd #(
  parameter int NUM_DIGITS = 3,            // 1..8 decades
  parameter int W          = 4*NUM_DIGITS  // derived width, leave at default
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         load,
  input  logic         up_down,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] count_out,
  output logic         tc,
  output logic         load_err
);

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // Registered state
  logic [W-1:0] count_q, count_d;
  logic         tc_q, tc_d;
  logic         load_err_q, load_err_d;

  // Candidate next values, computed unconditionally and selected below
  logic [W-1:0] count_inc;     // count_q + 1 with decimal carry ripple
  logic [W-1:0] count_dec;     // count_q - 1 with decimal borrow ripple
  logic         all_nines;     // count_q is the top of the range
  logic         all_zeros;     // count_q is the bottom of the range
  logic [W-1:0] load_clean;    // data_in with non-BCD digits forced to 0
  logic         load_bad;      // data_in contains at least one non-BCD digit

  // Decimal increment: a digit steps only when every lower digit was 9,
  // and digits that were 9 roll over to 0. The carry leaving the top digit
  // is therefore exactly "all digits were 9".
  always_comb begin : inc_calc
    logic       carry;
    logic [3:0] digit;
    // NOTE: every variable written in a combinational block gets a value at
    // the top of the block so no path leaves it unassigned (no latch).
    count_inc = count_q;
    carry     = 1'b1;
    digit     = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digit = count_q[4*k +: 4];
      if (carry) begin
        if (digit >= DIGIT_MAX) begin
          count_inc[4*k +: 4] = 4'd0;
        end else begin
          count_inc[4*k +: 4] = digit + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    all_nines = carry;
  end

  // Decimal decrement: a digit steps only when every lower digit was 0,
  // and digits that were 0 roll under to 9. The borrow leaving the top
  // digit is exactly "all digits were 0".
  always_comb begin : dec_calc
    logic       borrow;
    logic [3:0] digit;
    count_dec = count_q;
    borrow    = 1'b1;
    digit     = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digit = count_q[4*k +: 4];
      if (borrow) begin
        if (digit == 4'd0) begin
          count_dec[4*k +: 4] = DIGIT_MAX;
        end else if (digit > DIGIT_MAX) begin
          // Unreachable from any input sequence; steer to a legal digit.
          count_dec[4*k +: 4] = DIGIT_MAX;
          borrow              = 1'b0;
        end else begin
          count_dec[4*k +: 4] = digit - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
    all_zeros = borrow;
  end

  // Load validation: each nibble above 9 is replaced by 0 and flagged, so
  // the counter never holds a non-BCD digit.
  always_comb begin : load_check
    logic [3:0] nib;
    load_clean = '0;
    load_bad   = 1'b0;
    nib        = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nib = data_in[4*k +: 4];
      if (nib > DIGIT_MAX) begin
        load_clean[4*k +: 4] = 4'd0;
        load_bad             = 1'b1;
      end else begin
        load_clean[4*k +: 4] = nib;
      end
    end
  end

  // Next-state selection: load beats count, count beats hold. tc is a
  // one-edge pulse, so it defaults low and is raised only by a range event.
  always_comb begin : next_state
    count_d    = count_q;
    tc_d       = 1'b0;
    load_err_d = load_err_q;
    if (load) begin
      count_d    = load_clean;
      load_err_d = load_bad;
    end else if (en) begin
      if (up_down) begin
`ifdef BCD_COUNTER_SAT_EN
        if (all_nines) begin
          count_d = count_q;
          tc_d    = 1'b1;
        end else begin
          count_d = count_inc;
        end
`else
        count_d = count_inc;
        tc_d    = all_nines;
`endif
      end else begin
`ifdef BCD_COUNTER_SAT_EN
        if (all_zeros) begin
          count_d = count_q;
          tc_d    = 1'b1;
        end else begin
          count_d = count_dec;
        end
`else
        count_d = count_dec;
        tc_d    = all_zeros;
`endif
      end
    end
  end

  // State registers with asynchronous clear; a reset mid-count drops any
  // pending carry because all state is cleared together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge inputs regardless of statement order.
      count_q    <= count_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign count_out = count_q;
  assign tc        = tc_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter_nd.sv
// ---------------------------------------------------------------------------
// Self-checking bench for bcd_updown_counter_nd (NUM_DIGITS = 3).
// Table-driven single-edge vectors plus hand-written reset sequences.
// Expectations follow the wrap build unless BCD_COUNTER_SAT_EN is defined.
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter_nd;

  localparam int ND = 3;
  localparam int W  = 4*ND;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en;
  logic         load;
  logic         up_down;
  logic [W-1:0] data_in;
  logic [W-1:0] count_out;
  logic         tc;
  logic         load_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         load;
    logic         en;
    logic         up;
    logic [W-1:0] din;
    logic [W-1:0] exp_cnt;
    logic         exp_tc;
    logic         exp_err;
    string        name;
  } vec_t;

  vec_t vecs[$];

  bcd_updown_counter_nd #(.NUM_DIGITS(ND)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .load      (load),
    .up_down   (up_down),
    .data_in   (data_in),
    .count_out (count_out),
    .tc        (tc),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [W-1:0] c,
                           input logic t, input logic e);
    check({name, ".count"},    32'(count_out), 32'(c));
    check({name, ".tc"},       32'(tc),        32'(t));
    check({name, ".load_err"}, 32'(load_err),  32'(e));
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, sample 1 ns later.
  task automatic step(input logic l, input logic e, input logic u, input logic [W-1:0] d);
    @(negedge clk);
    load = l; en = e; up_down = u; data_in = d;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic l, input logic e, input logic u,
                              input logic [W-1:0] d, input logic [W-1:0] c,
                              input logic t, input logic er, input string n);
    vec_t v;
    v.load = l; v.en = e; v.up = u; v.din = d;
    v.exp_cnt = c; v.exp_tc = t; v.exp_err = er; v.name = n;
    vecs.push_back(v);
  endfunction

  initial begin
    reset_n = 1'b0; en = 1'b0; load = 1'b0; up_down = 1'b0; data_in = '0;

    // Reset state, checked before any clock edge
    #2;
    check_all("reset_initial", 12'h000, 1'b0, 1'b0);

    // Reset held across an edge with en high: still clear
    @(negedge clk); en = 1'b1; up_down = 1'b1;
    @(posedge clk); #1;
    check_all("reset_held_edge", 12'h000, 1'b0, 1'b0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check_all("reset_release_first_edge", 12'h001, 1'b0, 1'b0);

    // ---------------- vector table ----------------
    // load 0x998, then three up counts through the wrap
    add(1,0,0,12'h998, 12'h998,0,0,"ld_998");
    add(0,1,1,12'h000, 12'h999,0,0,"up_to_999");
`ifdef BCD_COUNTER_SAT_EN
    add(0,1,1,12'h000, 12'h999,1,0,"sat_up_1");
    add(0,1,1,12'h000, 12'h999,1,0,"sat_up_2");
`else
    add(0,1,1,12'h000, 12'h000,1,0,"up_wrap");
    add(0,1,1,12'h000, 12'h001,0,0,"up_after_wrap");
`endif
    // ripple borrow and down wrap
    add(1,0,1,12'h100, 12'h100,0,0,"ld_100");
    add(0,1,0,12'h000, 12'h099,0,0,"down_borrow");
    add(0,1,0,12'h000, 12'h098,0,0,"down_098");
    add(1,0,0,12'h000, 12'h000,0,0,"ld_000");
`ifdef BCD_COUNTER_SAT_EN
    add(0,1,0,12'h000, 12'h000,1,0,"sat_down");
    add(0,1,0,12'h000, 12'h000,1,0,"sat_down_2");
`else
    add(0,1,0,12'h000, 12'h999,1,0,"down_wrap");
    add(0,1,0,12'h000, 12'h998,0,0,"down_after_wrap");
`endif
    // ripple carry across two digits
    add(1,0,0,12'h099, 12'h099,0,0,"ld_099");
    add(0,1,1,12'h000, 12'h100,0,0,"up_ripple");
    // invalid load is sanitised and flagged; flag is sticky while counting
    add(1,0,0,12'h3B7, 12'h307,0,1,"ld_bad_3B7");
    add(0,1,1,12'h000, 12'h308,0,1,"bad_up_1");
    add(0,1,1,12'h000, 12'h309,0,1,"bad_up_2");
    add(0,0,1,12'h000, 12'h309,0,1,"bad_hold");
    add(1,0,0,12'h050, 12'h050,0,0,"ld_good_050");
    add(1,0,0,12'hFAF, 12'h000,0,1,"ld_all_bad");
    add(1,0,0,12'h5C0, 12'h500,0,1,"ld_mid_bad");
    // load beats enable on the same edge
    add(1,1,1,12'h123, 12'h123,0,0,"ld_with_en");
    add(1,1,0,12'h456, 12'h456,0,0,"ld_with_en_dn");
    // hold for five edges
    for (int i = 0; i < 5; i++) add(0,0,i[0],12'h999, 12'h456,0,0,"hold");
    // direction sampled per edge
    add(1,0,0,12'h010, 12'h010,0,0,"ld_010");
    add(0,1,1,12'h000, 12'h011,0,0,"toggle_up");
    add(0,1,0,12'h000, 12'h010,0,0,"toggle_dn");
    add(0,1,1,12'h000, 12'h011,0,0,"toggle_up2");
    // load clears a pending tc: wrap then load on the next edge
    add(1,0,0,12'h999, 12'h999,0,0,"ld_999");
`ifdef BCD_COUNTER_SAT_EN
    add(0,1,1,12'h000, 12'h999,1,0,"sat_top");
`else
    add(0,1,1,12'h000, 12'h000,1,0,"wrap_top");
`endif
    add(1,1,1,12'h042, 12'h042,0,0,"ld_clears_tc");

    foreach (vecs[i]) begin
      step(vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].din);
      check_all($sformatf("%s[%0d]", vecs[i].name, i),
                vecs[i].exp_cnt, vecs[i].exp_tc, vecs[i].exp_err);
    end

    // ---------------- async reset mid-count ----------------
    step(1,0,0,12'h457);                 // sets up a bad flag first? no: valid load
    step(1,0,0,12'hA57);                 // 0x057 with load_err=1
    check_all("pre_reset_ld", 12'h057, 1'b0, 1'b1);
    step(1,0,0,12'h457);
    step(0,1,1,12'h000);
    check_all("pre_reset_count", 12'h458, 1'b0, 1'b0);
    step(1,0,0,12'hB57);                 // 0x057, load_err=1 before reset
    // Assert reset between edges and look before the next edge
    #2 reset_n = 1'b0;
    #1;
    check_all("async_reset_no_edge", 12'h000, 1'b0, 1'b0);
    @(negedge clk); reset_n = 1'b1; en = 1'b1; up_down = 1'b0; load = 1'b0;
    @(posedge clk); #1;
`ifdef BCD_COUNTER_SAT_EN
    check_all("post_reset_down", 12'h000, 1'b1, 1'b0);
`else
    check_all("post_reset_down", 12'h999, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
